// File: rtl/seven_seg_dev.sv
// Four-digit seven-segment display driver: hex decode or raw segment bytes,
// with per-digit decimal point and blink control. Outputs are registered.
module seven_seg_dev (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] disp_num,
   input  logic [1:0]  SW,
   input  logic [1:0]  Scanning,
   input  logic [3:0]  pointing,
   input  logic [3:0]  blinking,
   input  logic        flash_clk,
   output logic [3:0]  AN,
   output logic [7:0]  SEGMENT
);

   logic [3:0] r_an;
   logic [7:0] r_seg;

   logic [3:0] w_nibble;
   logic [6:0] w_hexSeg;
   logic [7:0] w_rawByte;
   logic [3:0] w_nextAn;
   logic [7:0] w_nextSeg;
   logic       w_blank;

   // Active-low gfedcba pattern for one hex digit
   function automatic logic [6:0] hexDecode(input logic [3:0] n);
      logic [6:0] seg;
      case (n)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         default: seg = 7'h0E;
      endcase
      return seg;
   endfunction

   always_comb begin
      w_nibble  = disp_num[{SW[1], Scanning, 2'b00} +: 4];
      w_rawByte = disp_num[{Scanning, 3'b000} +: 8];
      w_hexSeg  = hexDecode(w_nibble);
      w_blank   = blinking[Scanning] & flash_clk;

      w_nextAn  = 4'hF;
      w_nextSeg = 8'hFF;
      // Blink blanking overrides both display modes
      if (!w_blank) begin
         w_nextAn[Scanning] = 1'b0;
         if (SW[0])
            w_nextSeg = {~pointing[Scanning], w_hexSeg};
         else
            w_nextSeg = w_rawByte;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_an  <= 4'hF;
         r_seg <= 8'hFF;
      end else begin
         r_an  <= w_nextAn;
         r_seg <= w_nextSeg;
      end
   end

   assign AN      = r_an;
   assign SEGMENT = r_seg;

endmodule

// File: tb/tb_seven_seg_dev.sv
// Directed self-checking bench for seven_seg_dev using immediate assertions
// against hand-computed AN/SEGMENT values.
module tb_seven_seg_dev;

   logic        clk;
   logic        rst;
   logic [31:0] disp_num;
   logic [1:0]  SW;
   logic [1:0]  Scanning;
   logic [3:0]  pointing;
   logic [3:0]  blinking;
   logic        flash_clk;
   logic [3:0]  AN;
   logic [7:0]  SEGMENT;

   int vectors;
   int miscompares;

   seven_seg_dev dut (
      .clk       (clk),
      .rst       (rst),
      .disp_num  (disp_num),
      .SW        (SW),
      .Scanning  (Scanning),
      .pointing  (pointing),
      .blinking  (blinking),
      .flash_clk (flash_clk),
      .AN        (AN),
      .SEGMENT   (SEGMENT)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one input vector, then let one rising edge register it
   task automatic applyStimulus(input logic r, input logic [31:0] num, input logic [1:0] sw,
                                input logic [1:0] scan, input logic [3:0] pt,
                                input logic [3:0] bl, input logic fl);
      rst       = r;
      disp_num  = num;
      SW        = sw;
      Scanning  = scan;
      pointing  = pt;
      blinking  = bl;
      flash_clk = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [3:0] expAn, input logic [7:0] expSeg);
      vectors++;
      assert ({AN, SEGMENT} === {expAn, expSeg})
      else begin
         miscompares++;
         $error("[TB] FAIL %s: AN/SEGMENT observed %b/%h expected %b/%h",
                tag, AN, SEGMENT, expAn, expSeg);
      end
   endtask

   logic [7:0] decodeTable [16];

   initial begin
      vectors     = 0;
      miscompares = 0;
      decodeTable = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

      // Reset dominates even with a visible digit requested
      applyStimulus(1'b1, 32'h12345678, 2'b01, 2'b00, 4'h1, 4'h0, 1'b0);
      checkOutput("reset_dark", 4'b1111, 8'hFF);
      applyStimulus(1'b1, 32'h12345678, 2'b01, 2'b10, 4'hF, 4'h0, 1'b0);
      checkOutput("reset_hold", 4'b1111, 8'hFF);

      // Hex low half
      applyStimulus(1'b0, 32'h12345678, 2'b01, 2'b00, 4'h0, 4'h0, 1'b0);
      checkOutput("hex_lo_d0", 4'b1110, 8'h80);
      applyStimulus(1'b0, 32'h12345678, 2'b01, 2'b01, 4'h0, 4'h0, 1'b0);
      checkOutput("hex_lo_d1", 4'b1101, 8'hF8);
      applyStimulus(1'b0, 32'h12345678, 2'b01, 2'b10, 4'h0, 4'h0, 1'b0);
      checkOutput("hex_lo_d2", 4'b1011, 8'h82);
      applyStimulus(1'b0, 32'h12345678, 2'b01, 2'b11, 4'h0, 4'h0, 1'b0);
      checkOutput("hex_lo_d3", 4'b0111, 8'h92);

      // Hex high half
      applyStimulus(1'b0, 32'h12345678, 2'b11, 2'b00, 4'h0, 4'h0, 1'b0);
      checkOutput("hex_hi_d0", 4'b1110, 8'h99);
      applyStimulus(1'b0, 32'h12345678, 2'b11, 2'b01, 4'h0, 4'h0, 1'b0);
      checkOutput("hex_hi_d1", 4'b1101, 8'hB0);
      applyStimulus(1'b0, 32'h12345678, 2'b11, 2'b10, 4'h0, 4'h0, 1'b0);
      checkOutput("hex_hi_d2", 4'b1011, 8'hA4);
      applyStimulus(1'b0, 32'h12345678, 2'b11, 2'b11, 4'h0, 4'h0, 1'b0);
      checkOutput("hex_hi_d3", 4'b0111, 8'hF9);

      // Graphic mode: raw bytes, pointing and SW[1] ignored
      applyStimulus(1'b0, 32'h557EF7E0, 2'b10, 2'b00, 4'hF, 4'h0, 1'b0);
      checkOutput("gfx_d0", 4'b1110, 8'hE0);
      applyStimulus(1'b0, 32'h557EF7E0, 2'b10, 2'b01, 4'hF, 4'h0, 1'b0);
      checkOutput("gfx_d1", 4'b1101, 8'hF7);
      applyStimulus(1'b0, 32'h557EF7E0, 2'b10, 2'b10, 4'hF, 4'h0, 1'b0);
      checkOutput("gfx_d2", 4'b1011, 8'h7E);
      applyStimulus(1'b0, 32'h557EF7E0, 2'b00, 2'b11, 4'hF, 4'h0, 1'b0);
      checkOutput("gfx_d3", 4'b0111, 8'h55);

      // Full hex decode table on digit 1 with its decimal point off
      for (int n = 0; n < 16; n++) begin
         logic [3:0] nib;
         nib = 4'(n);
         applyStimulus(1'b0, {8{nib}}, 2'b01, 2'b01, 4'b1101, 4'h0, 1'b0);
         checkOutput($sformatf("decode_%h", nib), 4'b1101, decodeTable[n]);
      end

      // Decimal point and blinking
      applyStimulus(1'b0, 32'h12345678, 2'b01, 2'b00, 4'b0001, 4'h0, 1'b0);
      checkOutput("dp_on", 4'b1110, 8'h00);
      applyStimulus(1'b0, 32'h12345678, 2'b01, 2'b00, 4'b0001, 4'b0001, 1'b1);
      checkOutput("blink_blank", 4'b1111, 8'hFF);
      applyStimulus(1'b0, 32'h12345678, 2'b01, 2'b00, 4'b0001, 4'b0001, 1'b0);
      checkOutput("blink_visible", 4'b1110, 8'h00);
      applyStimulus(1'b0, 32'h12345678, 2'b01, 2'b01, 4'b0001, 4'b0001, 1'b1);
      checkOutput("blink_other_digit", 4'b1101, 8'hF8);
      applyStimulus(1'b0, 32'h557EF7E0, 2'b00, 2'b11, 4'h0, 4'b1000, 1'b1);
      checkOutput("blink_gfx", 4'b1111, 8'hFF);

      // Mid-operation reset for one edge, then recovery
      applyStimulus(1'b0, 32'h12345678, 2'b01, 2'b10, 4'h0, 4'h0, 1'b0);
      checkOutput("pre_reset", 4'b1011, 8'h82);
      applyStimulus(1'b1, 32'h12345678, 2'b01, 2'b10, 4'h0, 4'h0, 1'b0);
      checkOutput("mid_reset", 4'b1111, 8'hFF);
      applyStimulus(1'b0, 32'h12345678, 2'b01, 2'b10, 4'h0, 4'h0, 1'b0);
      checkOutput("post_reset", 4'b1011, 8'h82);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/seven_seg_dev.md
SEVEN_SEG_DEV -- requirements
Module: seven_seg_dev

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 The block SHALL have port disp_num, input, 32 bits: display data, either eight hex nibbles or four raw segment bytes.
REQ-004 The block SHALL have port SW, input, 2 bits: SW[0]=1 selects hex mode, SW[0]=0 selects graphic mode; SW[1] selects the 16-bit half in hex mode.
REQ-005 The block SHALL have port Scanning, input, 2 bits: index of the digit currently driven, 0 = rightmost.
REQ-006 The block SHALL have port pointing, input, 4 bits: per-digit decimal-point enable, active-high, used in hex mode only.
REQ-007 The block SHALL have port blinking, input, 4 bits: per-digit blink enable, active-high.
REQ-008 The block SHALL have port flash_clk, input, 1 bit: blink phase level; 1 = blank phase.
REQ-009 The block SHALL have port AN, output, 4 bits: digit anode enables, active-low.
REQ-010 The block SHALL have port SEGMENT, output, 8 bits: active-low segments; bit 7 = dp, bits 6..0 = g,f,e,d,c,b,a.
REQ-011 The block SHALL use no parameters; all widths are fixed as listed.

Function
REQ-012 AN and SEGMENT SHALL be registered outputs that update one clk cycle after their inputs are sampled; they are constant between edges.
REQ-013 On each clock edge the block SHALL let i = Scanning.
REQ-014 The next AN value SHALL have bit i = 0 and all other bits = 1; Scanning 0,1,2,3 gives 1110, 1101, 1011, 0111.
REQ-015 In hex mode (SW[0]=1), the block SHALL select nibble n = disp_num[16*SW[1] + 4*i +: 4].
REQ-016 In hex mode, SEGMENT[6:0] SHALL be the active-low decode of n.
- Full SEGMENT values with dp off, n = 0..F: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90, 88, 83, C6, A1, 86, 8E.
REQ-017 In hex mode, SEGMENT[7] SHALL equal ~pointing[i].
REQ-018 In graphic mode (SW[0]=0), SEGMENT SHALL equal disp_num[8*i +: 8] passed through unmodified.
- SW[1] and pointing SHALL be ignored in graphic mode.
REQ-019 Blinking SHALL apply in both modes and takes priority over all other output logic.
- If blinking[i]=1 and flash_clk=1, the next AN SHALL be 1111 and the next SEGMENT SHALL be FF.
REQ-020 A change of SW, Scanning, disp_num or pointing SHALL take effect on the very next clock edge, with no pipeline bubble or glitch state.
REQ-021 flash_clk SHALL be treated as a synchronous data level and SHALL NOT be used as a clock.

Reset
REQ-022 While rst=1 at a rising edge, AN SHALL become 1111 and SEGMENT SHALL become FF (display dark), regardless of all other inputs.
REQ-023 If rst is asserted mid-operation, the outputs SHALL go dark on that same edge.
REQ-024 On the first edge after rst deasserts, normal decoding per REQ-012..REQ-021 SHALL resume.

Verification
REQ-025 The bench SHALL cover hex low half.
- Stimulus: disp_num=12345678, SW=01, pointing=0, blinking=0; Scanning=00, 01, 10, 11.
- Required response, one cycle later: AN/SEGMENT = 1110/80, 1101/F8, 1011/82, 0111/92.
REQ-026 The bench SHALL cover hex high half.
- Stimulus: disp_num=12345678, SW=11; Scanning=00, 01, 10, 11.
- Required response: SEGMENT = 99, B0, A4, F9.
REQ-027 The bench SHALL cover graphic mode.
- Stimulus: disp_num=557EF7E0, SW=10, pointing=F; Scanning=00, 01, 10, 11.
- Required response: SEGMENT = E0, F7, 7E, 55; pointing has no effect.
REQ-028 The bench SHALL cover the decimal point and blinking.
- Decimal point: SW=01, disp_num=12345678, pointing=0001, Scanning=00 -> SEGMENT=00.
- Blank: blinking=0001, flash_clk=1 -> AN=1111, SEGMENT=FF.
- Visible: flash_clk=0 -> AN=1110, SEGMENT=00.
REQ-029 The bench SHALL cover reset.
- Stimulus: rst=1 for one edge during a hex display.
- Required response: AN=1111 and SEGMENT=FF on that edge; the correct digit returns one edge after rst=0.
